// File: rtl/cpu_control_unit_if.sv
// Bus bundle between the accumulator CPU sequencer and its MainMemory / ALU.
//   mem_addr         : 16-bit memory address ({4'b0, 12-bit addr})
//   mem_wdata        : memory write data (the accumulator)
//   mem_write_enable : memory write strobe
//   mem_rdata        : memory read data, valid the cycle after the address
//   alu_opcode       : ALU function select
//   alu_operand1/2   : ALU operands (AC, MBR)
//   alu_result       : combinational ALU result
// master = sequencer side, slave = memory/ALU side.
interface cpu_control_unit_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write_enable;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_operand1;
  logic [15:0] alu_operand2;
  logic [15:0] alu_result;

  modport master (
    output mem_addr, mem_wdata, mem_write_enable,
    output alu_opcode, alu_operand1, alu_operand2,
    input  mem_rdata, alu_result
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_write_enable,
    input  alu_opcode, alu_operand1, alu_operand2,
    output mem_rdata, alu_result
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Holds PC, IR, MBR and AC and runs a single-issue multi-cycle FSM.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : memory + ALU bundle (master side)
//   pc     : program counter (12 bits)
//   ac     : accumulator
//   ir     : instruction register
//   halted : high while in HALTED
module cpu_control_unit (
  input  logic                clk,
  input  logic                reset,
  cpu_control_unit_if.master  bus,
  output logic [11:0]         pc,
  output logic [15:0]         ac,
  output logic [15:0]         ir,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_LATCH_IR, S_DECODE, S_OP_READ,
    S_OP_LATCH, S_EXECUTE, S_STORE, S_HALTED
  } state_t;

  // Instruction ops (IR[15:12])
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_CMPGT = 4'hC;
  localparam logic [3:0] OP_CMPEQ = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU function codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_MUL   = 4'b0010;
  localparam logic [3:0] ALU_SHL   = 4'b0100;
  localparam logic [3:0] ALU_SHR   = 4'b0101;
  localparam logic [3:0] ALU_AND   = 4'b1000;
  localparam logic [3:0] ALU_OR    = 4'b1001;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_CMPGT = 4'b1110;
  localparam logic [3:0] ALU_CMPEQ = 4'b1111;

  state_t      state;
  logic [15:0] mbr;
  logic [3:0]  op;
  logic [11:0] addr;
  logic [3:0]  alu_op;

  assign op   = ir[15:12];
  assign addr = ir[11:0];

  // ALU function is a pure decode of IR, so it is valid in every state and
  // is 0000 out of reset (IR=0 decodes as NOP).
  always_comb begin
    alu_op = ALU_ADD;
    case (op)
      OP_ADD:   alu_op = ALU_ADD;
      OP_SUB:   alu_op = ALU_SUB;
      OP_AND:   alu_op = ALU_AND;
      OP_OR:    alu_op = ALU_OR;
      OP_XOR:   alu_op = ALU_XOR;
      OP_SHL:   alu_op = ALU_SHL;
      OP_SHR:   alu_op = ALU_SHR;
      OP_CMPGT: alu_op = ALU_CMPGT;
      OP_CMPEQ: alu_op = ALU_CMPEQ;
      OP_MUL:   alu_op = ALU_MUL;
      default:  alu_op = ALU_ADD;
    endcase
  end

  // Memory and ALU drives depend only on registered state. The operand
  // address is presented only in OP_READ/STORE; elsewhere PC is shown so
  // the address bus never floats.
  assign bus.mem_addr     = (state == S_OP_READ || state == S_STORE) ?
                            {4'b0000, addr} : {4'b0000, pc};
  assign bus.mem_wdata    = ac;
  // Gated by reset so an aborted STORE never writes, even before the first edge.
  assign bus.mem_write_enable = (state == S_STORE) && !reset;
  assign bus.alu_opcode   = alu_op;
  assign bus.alu_operand1 = ac;
  assign bus.alu_operand2 = mbr;
  assign halted           = (state == S_HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= 12'h000;
      ir    <= 16'h0000;
      mbr   <= 16'h0000;
      ac    <= 16'h0000;
    end else begin
      case (state)
        S_FETCH: state <= S_LATCH_IR;

        S_LATCH_IR: begin
          ir    <= bus.mem_rdata;
          pc    <= pc + 12'd1;       // wraps FFF -> 000
          state <= S_DECODE;
        end

        S_DECODE: begin
          case (op)
            OP_NOP:  state <= S_FETCH;
            OP_JUMP: begin
              pc    <= addr;
              state <= S_FETCH;
            end
            OP_JZ: begin
              if (ac == 16'h0000) pc <= addr;
              state <= S_FETCH;
            end
            OP_HALT:        state <= S_HALTED;
            OP_SHL, OP_SHR: state <= S_EXECUTE;  // register-only ops
            OP_STORE:       state <= S_STORE;
            default:        state <= S_OP_READ;  // LOAD and memory-operand ALU ops
          endcase
        end

        S_OP_READ: state <= S_OP_LATCH;

        S_OP_LATCH: begin
          mbr   <= bus.mem_rdata;
          state <= S_EXECUTE;
        end

        S_EXECUTE: begin
          ac    <= (op == OP_LOAD) ? mbr : bus.alu_result;
          state <= S_FETCH;
        end

        S_STORE:  state <= S_FETCH;

        S_HALTED: state <= S_HALTED;

        default:  state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: behavioural memory + ALU, a vector table of
// single-instruction programs scored through an expectation queue, and
// hand-written sequences for the multi-cycle corner cases.
module tb_cpu_control_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] pc;
  logic [15:0] ac, ir;
  logic halted;
  int errors = 0;
  int checks = 0;

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pc(pc), .ac(ac), .ir(ir), .halted(halted)
  );

  always #5 clk = ~clk;

  // ---------------- memory / ALU models ----------------
  logic [15:0] mem [0:4095];

  always @(posedge clk) begin
    if (bus.mem_write_enable) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[11:0]];
  end

  function automatic logic [15:0] alu_f(input logic [3:0] opc,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = a * b;
    case (opc)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return p[15:0];
      4'b0100: return {a[14:0], 1'b0};
      4'b0101: return {1'b0, a[15:1]};
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b1110: return (a > b) ? 16'h0001 : 16'h0000;
      4'b1111: return (a == b) ? 16'h0001 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb bus.alu_result = alu_f(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2);

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  // Leaves the bench at the sampling point of cycle 0 (first FETCH).
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts cycles from cycle 0 until halted is seen; bounded.
  task automatic wait_halt(input string nm, output int cyc);
    cyc = 0;
    while (!halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL %s: halted never rose within %0d cycles", nm, cyc);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] instr;
    logic [15:0] init_ac;
    logic [15:0] operand;
    logic [15:0] exp_ac;
    logic [11:0] exp_pc;
    logic [15:0] exp_mem;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [15:0] ac;
    logic [11:0] pc;
    logic [15:0] memv;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  initial begin
    vec_t vecs[18];
    int cyc;
    exp_t e;
    logic [11:0] h_pc;
    logic [15:0] h_ac, h_ir;
    bit hold_bad;

    // Program per vector: M[0]=LOAD 100 (sets AC), M[1]=instr, M[2]=HALT,
    // M[5]=HALT (branch target), M[100]=init AC, M[101]=operand.
    // Cycles to halted = 6 (LOAD) + instr latency + 3 (HALT).
    vecs[0]  = '{16'h0000, 16'h0003, 16'h0011, 16'h0003, 12'h003, 16'h0011, 12}; // NOP
    vecs[1]  = '{16'h1101, 16'h0003, 16'h00AA, 16'h00AA, 12'h003, 16'h00AA, 15}; // LOAD
    vecs[2]  = '{16'h3101, 16'h0005, 16'h0007, 16'h000C, 12'h003, 16'h0007, 15}; // ADD
    vecs[3]  = '{16'h4101, 16'h0003, 16'h0005, 16'hFFFE, 12'h003, 16'h0005, 15}; // SUB wrap
    vecs[4]  = '{16'h5101, 16'hF0F0, 16'h0FF0, 16'h00F0, 12'h003, 16'h0FF0, 15}; // AND
    vecs[5]  = '{16'h6101, 16'hF0F0, 16'h0FF0, 16'hFFF0, 12'h003, 16'h0FF0, 15}; // OR
    vecs[6]  = '{16'h7101, 16'hF0F0, 16'h0FF0, 16'hFF00, 12'h003, 16'h0FF0, 15}; // XOR
    vecs[7]  = '{16'h8000, 16'h8001, 16'h0011, 16'h0002, 12'h003, 16'h0011, 13}; // SHL
    vecs[8]  = '{16'h9000, 16'h0002, 16'h0011, 16'h0001, 12'h003, 16'h0011, 13}; // SHR
    vecs[9]  = '{16'hC101, 16'h0001, 16'h0005, 16'h0000, 12'h003, 16'h0005, 15}; // CMPGT no
    vecs[10] = '{16'hC101, 16'h0009, 16'h0005, 16'h0001, 12'h003, 16'h0005, 15}; // CMPGT yes
    vecs[11] = '{16'hD101, 16'h0001, 16'h0001, 16'h0001, 12'h003, 16'h0001, 15}; // CMPEQ
    vecs[12] = '{16'hE101, 16'h0300, 16'h0101, 16'h0300, 12'h003, 16'h0101, 15}; // MUL low16
    vecs[13] = '{16'hA005, 16'h0003, 16'h0011, 16'h0003, 12'h006, 16'h0011, 12}; // JUMP
    vecs[14] = '{16'hB005, 16'h0000, 16'h0011, 16'h0000, 12'h006, 16'h0011, 12}; // JZ taken
    vecs[15] = '{16'hB005, 16'h0001, 16'h0011, 16'h0001, 12'h003, 16'h0011, 12}; // JZ not taken
    vecs[16] = '{16'h2101, 16'h1234, 16'h0011, 16'h1234, 12'h003, 16'h1234, 13}; // STORE
    vecs[17] = '{16'hF000, 16'h0007, 16'h0011, 16'h0007, 12'h002, 16'h0011, 9};  // HALT

    // ---- reset state ----
    clear_mem();
    #1;
    chk("we_before_first_edge", {31'b0, bus.mem_write_enable}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", {20'b0, pc}, 32'h0);
    chk("rst_ac", {16'b0, ac}, 32'h0);
    chk("rst_ir", {16'b0, ir}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_we", {31'b0, bus.mem_write_enable}, 32'h0);
    chk("rst_aluop", {28'b0, bus.alu_opcode}, 32'h0);
    chk("rst_addr", {16'b0, bus.mem_addr}, 32'h0);

    // ---- table-driven vectors through the scoreboard ----
    for (int i = 0; i < 18; i++) begin
      clear_mem();
      mem[12'h000] = 16'h1100;
      mem[12'h001] = vecs[i].instr;
      mem[12'h002] = 16'hF000;
      mem[12'h005] = 16'hF000;
      mem[12'h100] = vecs[i].init_ac;
      mem[12'h101] = vecs[i].operand;
      sb.push_back('{vecs[i].exp_ac, vecs[i].exp_pc, vecs[i].exp_mem, vecs[i].exp_cyc});
      do_reset();
      wait_halt($sformatf("vec%0d", i), cyc);
      if (halted && sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_ac", i), {16'b0, ac}, {16'b0, e.ac});
        chk($sformatf("vec%0d_pc", i), {20'b0, pc}, {20'b0, e.pc});
        chk($sformatf("vec%0d_mem", i), {16'b0, mem[12'h101]}, {16'b0, e.memv});
        chk($sformatf("vec%0d_cycles", i), cyc, e.cyc);
      end else if (sb.size() > 0) begin
        void'(sb.pop_front());
      end
    end

    // ---- load/add/store program ----
    clear_mem();
    mem[12'h000] = 16'h1010;
    mem[12'h001] = 16'h3011;
    mem[12'h002] = 16'h2012;
    mem[12'h003] = 16'hF000;
    mem[12'h010] = 16'h0005;
    mem[12'h011] = 16'h0007;
    do_reset();
    wait_halt("las", cyc);
    chk("las_cycles", cyc, 19);
    chk("las_mem12", {16'b0, mem[12'h012]}, 32'h000C);
    chk("las_ac", {16'b0, ac}, 32'h000C);
    chk("las_halted", {31'b0, halted}, 32'h1);

    // ---- halt hold, then reset restarts at 0 ----
    h_pc = pc; h_ac = ac; h_ir = ir;
    hold_bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pc !== h_pc || ac !== h_ac || ir !== h_ir ||
          bus.mem_write_enable !== 1'b0 || halted !== 1'b1) hold_bad = 1'b1;
    end
    chk("halt_hold_stable", {31'b0, hold_bad}, 32'h0);
    chk("halt_hold_pc", {20'b0, pc}, 32'h004);
    do_reset();
    chk("restart_addr", {16'b0, bus.mem_addr}, 32'h0);
    chk("restart_halted", {31'b0, halted}, 32'h0);
    step(2);
    chk("restart_ir", {16'b0, ir}, 32'h1010);

    // ---- PC wrap ----
    clear_mem();
    mem[12'h000] = 16'hAFFF;
    mem[12'hFFF] = 16'h0000;
    do_reset();
    step(3);
    chk("wrap_fetch_fff", {16'b0, bus.mem_addr}, 32'h0FFF);
    step(2);
    chk("wrap_pc", {20'b0, pc}, 32'h000);
    chk("wrap_ir", {16'b0, ir}, 32'h0000);
    step(1);
    chk("wrap_fetch0", {16'b0, bus.mem_addr}, 32'h0000);

    // ---- reset mid-STORE ----
    clear_mem();
    mem[12'h000] = 16'h1100;
    mem[12'h001] = 16'h2020;
    mem[12'h100] = 16'h1234;
    mem[12'h020] = 16'hBEEF;
    do_reset();
    step(9);   // LOAD takes cycles 0-5, STORE: F6 L7 D8 S9
    chk("mid_store_we", {31'b0, bus.mem_write_enable}, 32'h1);
    chk("mid_store_ac", {16'b0, ac}, 32'h1234);
    reset = 1'b1;
    #1;
    chk("mid_store_we_gated", {31'b0, bus.mem_write_enable}, 32'h0);
    @(negedge clk);
    chk("abort_mem", {16'b0, mem[12'h020]}, 32'hBEEF);
    chk("abort_pc", {20'b0, pc}, 32'h0);
    chk("abort_ac", {16'b0, ac}, 32'h0);
    chk("abort_we", {31'b0, bus.mem_write_enable}, 32'h0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
